// File: rtl/vec_mem_access_unit_if.sv
// Bundle between the EX/MEM register, the MEM-stage access unit, the data RAM
// and the MEM/WB register.
interface vec_mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
);
  logic              rmem;
  logic              wmem;
  logic              wreg;
  logic              VF;
  logic [3:0]        dest;
  logic [127:0]      addr_in;
  logic [127:0]      wdata_in;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              wb_wreg;
  logic              wb_VF;
  logic [3:0]        wb_dest;
  logic [127:0]      wb_data;

  modport slave (
    input  rmem, wmem, wreg, VF, dest, addr_in, wdata_in, mem_rdata,
    output stall, mem_addr, mem_we, mem_re, mem_wdata,
    output wb_wreg, wb_VF, wb_dest, wb_data
  );

  modport master (
    output rmem, wmem, wreg, VF, dest, addr_in, wdata_in, mem_rdata,
    input  stall, mem_addr, mem_we, mem_re, mem_wdata,
    input  wb_wreg, wb_VF, wb_dest, wb_data
  );
endinterface

// File: rtl/vec_mem_access_unit.sv
// MEM stage of the vector ASIP: scalar (1-beat) or vector (4-beat) word accesses
// to the data RAM, stalling upstream until the MEM/WB bundle is ready.
module vec_mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  vec_mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [ADDR_W-1:0] r_base;
  logic [127:0]      r_addr;
  logic [127:0]      r_wdata;
  logic              r_vf;
  logic [3:0]        r_dest;
  logic              r_wreg;
  logic              r_isStore;
  logic [127:0]      r_rbuf;
  logic              r_rdValid;
  logic [1:0]        r_rdBeat;

  logic w_req;
  logic w_lastBeat;

  assign w_req      = bus.rmem | bus.wmem;
  assign w_lastBeat = r_vf ? (r_beat == 2'd3) : 1'b1;

  // Reset forces stall low even while the request is still being presented.
  assign bus.stall = ~rst & ((r_state == S_IDLE & w_req) |
                             (r_state == S_ACCESS) |
                             (r_state == S_WAIT));

  assign bus.mem_addr  = r_base + ADDR_W'(r_beat);
  assign bus.mem_we    = (r_state == S_ACCESS) & r_isStore;
  assign bus.mem_re    = (r_state == S_ACCESS) & ~r_isStore;
  assign bus.mem_wdata = r_wdata[{r_beat, 5'b0} +: WORD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_base      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_vf        <= 1'b0;
      r_dest      <= 4'd0;
      r_wreg      <= 1'b0;
      r_isStore   <= 1'b0;
      r_rbuf      <= '0;
      r_rdValid   <= 1'b0;
      r_rdBeat    <= 2'd0;
      bus.wb_wreg <= 1'b0;
      bus.wb_VF   <= 1'b0;
      bus.wb_dest <= 4'd0;
      bus.wb_data <= '0;
    end else begin
      // Read data arrives one cycle after the strobe; remember which beat it belongs to.
      r_rdValid <= (r_state == S_ACCESS) & ~r_isStore;
      r_rdBeat  <= r_beat;
      if (r_rdValid) begin
        r_rbuf[{r_rdBeat, 5'b0} +: WORD_W] <= bus.mem_rdata;
      end

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_base    <= bus.addr_in[ADDR_W-1:0];
            r_addr    <= bus.addr_in;
            r_wdata   <= bus.wdata_in;
            r_vf      <= bus.VF;
            r_dest    <= bus.dest;
            r_wreg    <= bus.wreg;
            r_isStore <= bus.wmem;
            r_beat    <= 2'd0;
            r_state   <= S_ACCESS;
          end else begin
            bus.wb_wreg <= bus.wreg;
            bus.wb_VF   <= bus.VF;
            bus.wb_dest <= bus.dest;
            bus.wb_data <= bus.addr_in;
          end
        end
        S_ACCESS: begin
          if (w_lastBeat) begin
            r_state <= r_isStore ? S_DONE : S_WAIT;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        S_WAIT: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          bus.wb_wreg <= r_wreg;
          bus.wb_VF   <= r_vf;
          bus.wb_dest <= r_dest;
          if (r_isStore) begin
            bus.wb_data <= r_addr;
          end else begin
            bus.wb_data <= r_vf ? r_rbuf : {96'b0, r_rbuf[31:0]};
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_access_unit.sv
// Directed bench for vec_mem_access_unit with a behavioural one-cycle-read data RAM.
module tb_vec_mem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0]  ram [0:65535];
  logic [127:0] vecData;
  logic [127:0] wrapAddr;
  logic [15:0]  expAddr;

  vec_mem_access_unit_if #(.ADDR_W(16), .WORD_W(32)) bus ();

  vec_mem_access_unit #(.ADDR_W(16), .WORD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM: synchronous write, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rmem, input logic wmem, input logic wreg,
                               input logic vf, input logic [3:0] dest,
                               input logic [127:0] addr, input logic [127:0] wdata);
    bus.rmem     = rmem;
    bus.wmem     = wmem;
    bus.wreg     = wreg;
    bus.VF       = vf;
    bus.dest     = dest;
    bus.addr_in  = addr;
    bus.wdata_in = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkWb(input string tag, input logic wreg, input logic vf,
                         input logic [3:0] dest, input logic [127:0] data);
    checkOutput({tag, "_wreg"}, 128'(bus.wb_wreg), 128'(wreg));
    checkOutput({tag, "_vf"},   128'(bus.wb_VF),   128'(vf));
    checkOutput({tag, "_dest"}, 128'(bus.wb_dest), 128'(dest));
    checkOutput({tag, "_data"}, bus.wb_data, data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecData  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    bus.mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    $display("[TB] reset state");
    checkWb("reset", 1'b0, 1'b0, 4'd0, '0);
    checkOutput("reset_stall", 128'(bus.stall), 128'(0));
    checkOutput("reset_we", 128'(bus.mem_we), 128'(0));
    checkOutput("reset_re", 128'(bus.mem_re), 128'(0));
    #2 rst = 1'b0;
    tick();

    $display("[TB] vector store at 0x0010");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 128'h10, vecData);
    #1;
    checkOutput("vst_idle_stall", 128'(bus.stall), 128'(1));
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("vst_stall", 128'(bus.stall), 128'(1));
      checkOutput("vst_we", 128'(bus.mem_we), 128'(1));
      checkOutput("vst_re", 128'(bus.mem_re), 128'(0));
      checkOutput("vst_addr", 128'(bus.mem_addr), 128'(16'h10 + 16'(k)));
      checkOutput("vst_wdata", 128'(bus.mem_wdata), 128'(vecData[32*k +: 32]));
      tick();
    end
    checkOutput("vst_done_stall", 128'(bus.stall), 128'(0));
    checkOutput("vst_done_we", 128'(bus.mem_we), 128'(0));
    checkWb("vst_hold", 1'b0, 1'b0, 4'd0, '0);
    tick();
    checkWb("vst_wb", 1'b0, 1'b1, 4'd3, 128'h10);
    checkOutput("vst_ram12", 128'(ram[16'h12]), 128'(32'hCCCCCCCC));

    $display("[TB] vector load at 0x0010");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 128'h10, '0);
    #1;
    checkOutput("vld_idle_stall", 128'(bus.stall), 128'(1));
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("vld_stall", 128'(bus.stall), 128'(1));
      checkOutput("vld_re", 128'(bus.mem_re), 128'(1));
      checkOutput("vld_we", 128'(bus.mem_we), 128'(0));
      checkOutput("vld_addr", 128'(bus.mem_addr), 128'(16'h10 + 16'(k)));
      tick();
    end
    checkOutput("vld_wait_stall", 128'(bus.stall), 128'(1));
    checkOutput("vld_wait_re", 128'(bus.mem_re), 128'(0));
    tick();
    checkOutput("vld_done_stall", 128'(bus.stall), 128'(0));
    checkWb("vld_hold", 1'b0, 1'b1, 4'd3, 128'h10);
    tick();
    checkWb("vld_wb", 1'b1, 1'b1, 4'd7, vecData);

    $display("[TB] scalar load at 0x0012");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 128'h12, '0);
    #1;
    checkOutput("sld_idle_stall", 128'(bus.stall), 128'(1));
    tick();
    checkOutput("sld_re", 128'(bus.mem_re), 128'(1));
    checkOutput("sld_addr", 128'(bus.mem_addr), 128'(16'h12));
    tick();
    checkOutput("sld_wait_stall", 128'(bus.stall), 128'(1));
    checkOutput("sld_wait_re", 128'(bus.mem_re), 128'(0));
    tick();
    checkOutput("sld_done_stall", 128'(bus.stall), 128'(0));
    tick();
    checkWb("sld_wb", 1'b1, 1'b0, 4'd2, {96'b0, 32'hCCCCCCCC});

    $display("[TB] vector store at 0xFFFE with rmem and wmem both set");
    wrapAddr = 128'h5_0000_FFFE;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, wrapAddr, vecData);
    tick();
    expAddr = 16'hFFFE;
    for (int k = 0; k < 4; k++) begin
      checkOutput("wrap_addr", 128'(bus.mem_addr), 128'(expAddr));
      checkOutput("wrap_we", 128'(bus.mem_we), 128'(1));
      checkOutput("wrap_re", 128'(bus.mem_re), 128'(0));
      expAddr = expAddr + 16'd1;
      tick();
    end
    checkOutput("wrap_done_stall", 128'(bus.stall), 128'(0));
    tick();
    checkWb("wrap_wb", 1'b0, 1'b1, 4'd1, wrapAddr);
    checkOutput("wrap_ram0001", 128'(ram[16'h0001]), 128'(32'hDDDDDDDD));

    $display("[TB] scalar store at 0x0020");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 128'h20, 128'h9_12345678);
    tick();
    checkOutput("sst_we", 128'(bus.mem_we), 128'(1));
    checkOutput("sst_wdata", 128'(bus.mem_wdata), 128'(32'h12345678));
    tick();
    checkOutput("sst_done_stall", 128'(bus.stall), 128'(0));
    checkOutput("sst_done_we", 128'(bus.mem_we), 128'(0));
    tick();
    checkWb("sst_wb", 1'b0, 1'b0, 4'd4, 128'h20);

    $display("[TB] non-memory passthrough");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 128'h1234, '0);
    #1;
    checkOutput("alu_stall", 128'(bus.stall), 128'(0));
    tick();
    checkWb("alu_wb", 1'b1, 1'b0, 4'd5, 128'h1234);

    $display("[TB] reset during vector load beat 2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 128'h10, '0);
    tick();
    tick();
    tick();
    checkOutput("rst_pre_re", 128'(bus.mem_re), 128'(1));
    checkOutput("rst_pre_addr", 128'(bus.mem_addr), 128'(16'h12));
    rst = 1'b1;
    #1;
    checkOutput("rst_re", 128'(bus.mem_re), 128'(0));
    checkOutput("rst_stall", 128'(bus.stall), 128'(0));
    checkWb("rst_wb", 1'b0, 1'b0, 4'd0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
    tick();
    #2 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 128'hBEEF, '0);
    tick();
    checkWb("post_rst_alu", 1'b1, 1'b0, 4'd9, 128'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 128'h11, '0);
    tick();
    tick();
    tick();
    checkOutput("post_rst_done_stall", 128'(bus.stall), 128'(0));
    tick();
    checkWb("post_rst_sld", 1'b1, 1'b0, 4'd8, {96'b0, 32'hBBBBBBBB});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
